pmem_line_arbiter: RTL and testbench

//  Responder side of the cacheline (_cla) request interface. Serves two requesters, the LSQ/data-cache miss path
//  and the next-line prefetcher, onto a single 256-bit cacheline memory port. Drives arbiter_idle back to the prefetcher.

---
 rtl/pmem_line_arbiter_if.sv | 45 ++++
 rtl/pmem_line_arbiter.sv | 156 +++++++++++++++
 tb/tb_pmem_line_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_line_arbiter_if.sv
// Cacheline request bundle: LSQ and prefetcher requester ports plus the shared memory port.
// The arbiter uses the slave view; the requesters/memory side uses the master view.
interface pmem_line_arbiter_if;
   logic         lsq_pmem_read_cla;
   logic         lsq_pmem_write_cla;
   logic [31:0]  lsq_pmem_address_cla;
   logic [255:0] lsq_pmem_wdata_256_cla;
   logic         lsq_pmem_resp_cla;
   logic [255:0] lsq_pmem_rdata_256_cla;

   logic         pref_pmem_read_cla;
   logic         pref_pmem_write_cla;
   logic [31:0]  pref_pmem_address_cla;
   logic         pref_pmem_resp_cla;
   logic [255:0] pref_pmem_rdata_256_cla;

   logic         arbiter_idle;

   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata_256;
   logic         mem_resp;
   logic [255:0] mem_rdata_256;

   modport slave (
      input  lsq_pmem_read_cla, lsq_pmem_write_cla, lsq_pmem_address_cla, lsq_pmem_wdata_256_cla,
      output lsq_pmem_resp_cla, lsq_pmem_rdata_256_cla,
      input  pref_pmem_read_cla, pref_pmem_write_cla, pref_pmem_address_cla,
      output pref_pmem_resp_cla, pref_pmem_rdata_256_cla,
      output arbiter_idle,
      output mem_read, mem_write, mem_address, mem_wdata_256,
      input  mem_resp, mem_rdata_256
   );

   modport master (
      output lsq_pmem_read_cla, lsq_pmem_write_cla, lsq_pmem_address_cla, lsq_pmem_wdata_256_cla,
      input  lsq_pmem_resp_cla, lsq_pmem_rdata_256_cla,
      output pref_pmem_read_cla, pref_pmem_write_cla, pref_pmem_address_cla,
      input  pref_pmem_resp_cla, pref_pmem_rdata_256_cla,
      input  arbiter_idle,
      input  mem_read, mem_write, mem_address, mem_wdata_256,
      output mem_resp, mem_rdata_256
   );
endinterface

// File: rtl/pmem_line_arbiter.sv
// Arbitrates LSQ miss traffic and next-line prefetches onto one 256-bit cacheline memory port.
// Define PREF_BUF_EN to add a one-line prefetch buffer that LSQ reads can hit without memory.
module pmem_line_arbiter #(
   parameter int unsigned LINE_OFFSET = 5
) (
   input logic              clk,
   input logic              rst,
   pmem_line_arbiter_if.slave bus
);

   localparam int unsigned TagW = 32 - LINE_OFFSET;

`ifdef PREF_BUF_EN
   typedef enum logic [1:0] {StIdle, StServeLsq, StServePref, StBufHit} state_e;
`else
   typedef enum logic [1:0] {StIdle, StServeLsq, StServePref} state_e;
`endif

   state_e         state_q, state_d;
   logic [31:0]    addr_q, addr_d;
   logic [255:0]   wdata_q, wdata_d;
   logic           wr_q, wr_d;
   logic           lsq_resp, pref_resp;
   logic           lsq_req;
   logic [31:0]    lsq_addr_al, pref_addr_al;

`ifdef PREF_BUF_EN
   logic           buf_valid_q, buf_valid_d;
   logic [TagW-1:0] buf_tag_q, buf_tag_d;
   logic [255:0]   buf_line_q, buf_line_d;
   logic           lsq_tag_hit;
`endif

   logic unused_offset_bits;
   assign unused_offset_bits = ^{bus.lsq_pmem_address_cla[LINE_OFFSET-1:0],
                                 bus.pref_pmem_address_cla[LINE_OFFSET-1:0],
                                 bus.pref_pmem_write_cla};

   assign lsq_req      = bus.lsq_pmem_read_cla | bus.lsq_pmem_write_cla;
   assign lsq_addr_al  = {bus.lsq_pmem_address_cla[31:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
   assign pref_addr_al = {bus.pref_pmem_address_cla[31:LINE_OFFSET], {LINE_OFFSET{1'b0}}};

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      lsq_resp  = 1'b0;
      pref_resp = 1'b0;
`ifdef PREF_BUF_EN
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_line_d  = buf_line_q;
      lsq_tag_hit = buf_valid_q && (buf_tag_q == bus.lsq_pmem_address_cla[31:LINE_OFFSET]);
`endif
      unique case (state_q)
         StIdle: begin
            if (lsq_req) begin
               addr_d  = lsq_addr_al;
               wdata_d = bus.lsq_pmem_wdata_256_cla;
               wr_d    = bus.lsq_pmem_write_cla;
               state_d = StServeLsq;
`ifdef PREF_BUF_EN
               if (!bus.lsq_pmem_write_cla && lsq_tag_hit) begin
                  state_d = StBufHit;
               end else if (bus.lsq_pmem_write_cla && lsq_tag_hit) begin
                  // Stale after this write, so drop it before the write reaches memory
                  buf_valid_d = 1'b0;
               end
`endif
            end else if (bus.pref_pmem_read_cla) begin
               addr_d  = pref_addr_al;
               wdata_d = '0;
               wr_d    = 1'b0;
               state_d = StServePref;
            end
         end
         StServeLsq: begin
            if (bus.mem_resp) begin
               lsq_resp = 1'b1;
               state_d  = StIdle;
            end
         end
         StServePref: begin
            if (bus.mem_resp) begin
               pref_resp = 1'b1;
               state_d   = StIdle;
`ifdef PREF_BUF_EN
               buf_valid_d = 1'b1;
               buf_tag_d   = addr_q[31:LINE_OFFSET];
               buf_line_d  = bus.mem_rdata_256;
`endif
            end
         end
`ifdef PREF_BUF_EN
         StBufHit: begin
            lsq_resp = 1'b1;
            state_d  = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
      // An abandoned transaction never completes, even if memory answers during reset
      if (rst) begin
         lsq_resp  = 1'b0;
         pref_resp = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
`ifdef PREF_BUF_EN
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_line_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
`ifdef PREF_BUF_EN
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_line_q  <= buf_line_d;
`endif
      end
   end

   logic serving;
   assign serving = (state_q == StServeLsq) || (state_q == StServePref);

   assign bus.arbiter_idle       = (state_q == StIdle);
   assign bus.mem_read           = serving && !wr_q;
   assign bus.mem_write          = serving && wr_q;
   assign bus.mem_address        = addr_q;
   assign bus.mem_wdata_256      = wdata_q;
   assign bus.lsq_pmem_resp_cla  = lsq_resp;
   assign bus.pref_pmem_resp_cla = pref_resp;
   assign bus.pref_pmem_rdata_256_cla = pref_resp ? bus.mem_rdata_256 : '0;
`ifdef PREF_BUF_EN
   assign bus.lsq_pmem_rdata_256_cla =
      !lsq_resp ? '0 : (state_q == StBufHit) ? buf_line_q : bus.mem_rdata_256;
`else
   assign bus.lsq_pmem_rdata_256_cla = lsq_resp ? bus.mem_rdata_256 : '0;
`endif

   pref_write_unsupported_a: assert property (@(posedge clk) disable iff (rst)
      !bus.pref_pmem_write_cla)
      else $error("prefetcher issued an unsupported write");

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Scoreboard bench for pmem_line_arbiter: memory model pops expected transactions, monitor pops
// expected responses. Buffer scenarios run only when PREF_BUF_EN is defined.
module tb_pmem_line_arbiter;

   localparam int MemLat  = 3;
   localparam int Timeout = 30;

   logic clk = 1'b0;
   logic rst;

   pmem_line_arbiter_if bus ();

   pmem_line_arbiter #(.LINE_OFFSET(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
   } mem_txn_t;

   typedef struct packed {
      logic         wr;
      logic [255:0] rdata;
   } resp_t;

   mem_txn_t     exp_mem[$];
   resp_t        exp_lsq[$];
   logic [255:0] exp_pref[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Memory model: checks each new request against the expected queue, answers after MemLat cycles
   initial begin
      int       cnt;
      mem_txn_t cur;
      cnt = 0;
      cur = '0;
      bus.mem_resp      = 1'b0;
      bus.mem_rdata_256 = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_resp) begin
            bus.mem_resp      = 1'b0;
            bus.mem_rdata_256 = '0;
            cnt = 0;
            check_eq("mem_gap_after_resp", {bus.mem_read, bus.mem_write}, 2'b00);
         end else if (bus.mem_read || bus.mem_write) begin
            if (cnt == 0) begin
               if (exp_mem.size() == 0) begin
                  check_eq("mem_unexpected_req", {bus.mem_read, bus.mem_write}, 2'b00);
               end else begin
                  cur = exp_mem.pop_front();
                  check_eq("mem_write", bus.mem_write, cur.wr);
                  check_eq("mem_read", bus.mem_read, !cur.wr);
                  check_eq("mem_address", bus.mem_address, cur.addr);
                  if (cur.wr) check_eq("mem_wdata", bus.mem_wdata_256, cur.wdata);
               end
            end
            cnt++;
            if (cnt == MemLat) begin
               bus.mem_resp      = 1'b1;
               bus.mem_rdata_256 = cur.rdata;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Response monitor
   always @(negedge clk) begin
      resp_t        r;
      logic [255:0] pl;
      if (bus.lsq_pmem_resp_cla) begin
         if (exp_lsq.size() == 0) begin
            check_eq("lsq_unexpected_resp", bus.lsq_pmem_resp_cla, 1'b0);
         end else begin
            r = exp_lsq.pop_front();
            if (!r.wr) check_eq("lsq_rdata", bus.lsq_pmem_rdata_256_cla, r.rdata);
         end
      end
      if (bus.pref_pmem_resp_cla) begin
         if (exp_pref.size() == 0) begin
            check_eq("pref_unexpected_resp", bus.pref_pmem_resp_cla, 1'b0);
         end else begin
            pl = exp_pref.pop_front();
            check_eq("pref_rdata", bus.pref_pmem_rdata_256_cla, pl);
         end
      end
   end

   task automatic lsq_txn(input logic wr, input logic [31:0] a, input logic [255:0] wd,
                          input bit hit, input logic [255:0] hit_line, output int lat);
      mem_txn_t t;
      resp_t    r;
      t.wr    = wr;
      t.addr  = {a[31:5], 5'b0};
      t.wdata = wr ? wd : '0;
      t.rdata = rand_line();
      r.wr    = wr;
      r.rdata = hit ? hit_line : t.rdata;
      if (!hit) exp_mem.push_back(t);
      exp_lsq.push_back(r);
      bus.lsq_pmem_read_cla      = !wr;
      bus.lsq_pmem_write_cla     = wr;
      bus.lsq_pmem_address_cla   = a;
      bus.lsq_pmem_wdata_256_cla = wd;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.lsq_pmem_resp_cla && lat < Timeout);
      check_eq("lsq_resp_seen", bus.lsq_pmem_resp_cla, 1'b1);
      @(posedge clk);
      #1;
      bus.lsq_pmem_read_cla  = 1'b0;
      bus.lsq_pmem_write_cla = 1'b0;
   endtask

   task automatic pref_txn(input logic [31:0] a, output logic [255:0] line);
      mem_txn_t t;
      int       n;
      t.wr    = 1'b0;
      t.addr  = {a[31:5], 5'b0};
      t.wdata = '0;
      t.rdata = rand_line();
      line    = t.rdata;
      exp_mem.push_back(t);
      exp_pref.push_back(t.rdata);
      bus.pref_pmem_read_cla    = 1'b1;
      bus.pref_pmem_address_cla = a;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.pref_pmem_resp_cla && n < Timeout);
      check_eq("pref_resp_seen", bus.pref_pmem_resp_cla, 1'b1);
      @(posedge clk);
      #1;
      bus.pref_pmem_read_cla = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int           lat;
      logic [255:0] pline;
      mem_txn_t     t;
      rst = 1'b1;
      bus.lsq_pmem_read_cla      = 1'b0;
      bus.lsq_pmem_write_cla     = 1'b0;
      bus.lsq_pmem_address_cla   = '0;
      bus.lsq_pmem_wdata_256_cla = '0;
      bus.pref_pmem_read_cla     = 1'b0;
      bus.pref_pmem_write_cla    = 1'b0;
      bus.pref_pmem_address_cla  = '0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_idle", bus.arbiter_idle, 1'b1);
      check_eq("rst_mem_req", {bus.mem_read, bus.mem_write}, 2'b00);
      check_eq("rst_mem_address", bus.mem_address, 32'h0);
      check_eq("rst_mem_wdata", bus.mem_wdata_256, '0);
      check_eq("rst_resps", {bus.lsq_pmem_resp_cla, bus.pref_pmem_resp_cla}, 2'b00);
      check_eq("rst_lsq_rdata", bus.lsq_pmem_rdata_256_cla, '0);
      rst = 1'b0;
      @(posedge clk);
      #2;

      // Single LSQ read, unaligned address
      lsq_txn(1'b0, 32'h1000_0024, '0, 1'b0, '0, lat);
      check_eq("t1_latency", lat, MemLat + 1);
      check_eq("t1_idle_after", bus.arbiter_idle, 1'b1);

      // LSQ and prefetch in the same idle cycle: LSQ first
      @(posedge clk);
      #2;
      fork
         lsq_txn(1'b0, 32'h0000_0300, '0, 1'b0, '0, lat);
         begin
            #1;
            pref_txn(32'h0000_0040, pline);
         end
      join

      // Prefetch in flight, then an LSQ write arrives and waits
      @(posedge clk);
      #2;
      fork
         pref_txn(32'h0000_0500, pline);
         begin
            repeat (2) @(posedge clk);
            #2;
            check_eq("t3_busy", bus.arbiter_idle, 1'b0);
            lsq_txn(1'b1, 32'h0000_0080, rand_line(), 1'b0, '0, lat);
         end
      join

      // Reset during SERVE_LSQ abandons the request
      @(posedge clk);
      #2;
      t.wr = 1'b0; t.addr = 32'h0000_0200; t.wdata = '0; t.rdata = rand_line();
      exp_mem.push_back(t);
      bus.lsq_pmem_read_cla    = 1'b1;
      bus.lsq_pmem_address_cla = 32'h0000_0200;
      @(posedge clk);
      #2;
      check_eq("t4_serving_idle", bus.arbiter_idle, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      bus.lsq_pmem_read_cla = 1'b0;
      @(posedge clk);
      #2;
      check_eq("t4_rst_mem_read", bus.mem_read, 1'b0);
      check_eq("t4_rst_idle", bus.arbiter_idle, 1'b1);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #2;

`ifdef PREF_BUF_EN
      // Prefetched line serves an LSQ read in the same line without memory
      pref_txn(32'h0000_0100, pline);
      @(posedge clk);
      #2;
      lsq_txn(1'b0, 32'h0000_0104, '0, 1'b1, pline, lat);
      check_eq("t5_hit_latency", lat, 2);
      // A write to the buffered line invalidates it; the following read goes to memory
      @(posedge clk);
      #2;
      lsq_txn(1'b1, 32'h0000_0100, rand_line(), 1'b0, '0, lat);
      @(posedge clk);
      #2;
      lsq_txn(1'b0, 32'h0000_0100, '0, 1'b0, '0, lat);
      check_eq("t6_miss_latency", lat, MemLat + 1);
`endif

      repeat (4) @(posedge clk);
      #2;
      check_eq("mem_queue_drained", exp_mem.size(), 0);
      check_eq("lsq_queue_drained", exp_lsq.size(), 0);
      check_eq("pref_queue_drained", exp_pref.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
